// File: rtl/lake_spec_mem.sv
// Statically scheduled single-write / single-read buffer driven by two affine iteration domains.
// Optional macro LAKE_SPEC_RAW_BYPASS_EN forwards port_0 to a same-cycle same-address read.
`timescale 1ns/1ps
module lake_spec_mem #(
   parameter int DATA_WIDTH = 16,
   parameter int MEM_DEPTH  = 256,
   parameter int NUM_DIMS   = 4,
   parameter int CFG_WIDTH  = 550
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic [CFG_WIDTH-1:0]  config_memory_size_550,
   input  logic [DATA_WIDTH-1:0] port_0,
   output logic [DATA_WIDTH-1:0] port_1
);

   localparam int REC_W = CFG_WIDTH / 2;
   localparam int AW    = $clog2(MEM_DEPTH);

   logic [63:0] cyc;
   logic [1:0]  fire;
   logic [15:0] gen_addr [2];

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cyc <= '0;
      end else if (flush) begin
         cyc <= '0;
      end else begin
         cyc <= cyc + 64'd1;
      end
   end

   // Port 0 is the write domain, port 1 the read domain; both share one record layout.
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [REC_W-1:0] rec;
      logic [2:0]       dim;
      logic [15:0]      aoff;
      logic [63:0]      soff;
      logic [15:0]      ext    [NUM_DIMS];
      logic [15:0]      astr   [NUM_DIMS];
      logic [15:0]      sstr   [NUM_DIMS];
      logic [15:0]      it     [NUM_DIMS];
      logic [15:0]      it_nxt [NUM_DIMS];
      logic [15:0]      addr;
      logic [63:0]      sched;
      logic             carry;
      logic             wrap;
      logic             done;

      assign rec  = config_memory_size_550[p*REC_W +: REC_W];
      assign dim  = (rec[2:0] > 3'd4) ? 3'd4 : rec[2:0];
      assign aoff = rec[146:131];
      assign soff = rec[274:211];

      always_comb begin
         addr  = aoff;
         sched = soff;
         carry = 1'b1;
         for (int k = 0; k < NUM_DIMS; k++) begin
            ext[k]    = (rec[3+16*k +: 16] == 16'd0) ? 16'd1 : rec[3+16*k +: 16];
            astr[k]   = rec[67+16*k +: 16];
            sstr[k]   = rec[147+16*k +: 16];
            addr      = addr + astr[k] * it[k];
            sched     = sched + 64'(sstr[k]) * 64'(it[k]);
            it_nxt[k] = it[k];
            // Odometer step: a dimension moves only while every inner one is wrapping.
            if (k < int'(dim) && carry) begin
               if (it[k] == ext[k] - 16'd1) begin
                  it_nxt[k] = '0;
               end else begin
                  it_nxt[k] = it[k] + 16'd1;
                  carry     = 1'b0;
               end
            end
         end
         wrap = carry;
      end

      assign fire[p]     = !done && (dim != 3'd0) && (cyc == sched) && !flush;
      assign gen_addr[p] = addr;

      always_ff @(posedge clk or posedge rst_n) begin
         if (rst_n) begin
            for (int k = 0; k < NUM_DIMS; k++) it[k] <= '0;
            done <= 1'b0;
         end else if (flush) begin
            for (int k = 0; k < NUM_DIMS; k++) it[k] <= '0;
            done <= 1'b0;
         end else if (fire[p]) begin
            for (int k = 0; k < NUM_DIMS; k++) it[k] <= it_nxt[k];
            done <= wrap;
         end
      end
   end

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
   logic [AW-1:0]         waddr;
   logic [AW-1:0]         raddr;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  unused_addr_bits;

   assign waddr = gen_addr[0][AW-1:0];
   assign raddr = gen_addr[1][AW-1:0];
   // Generated addresses are 16 bits wide; only the low bits select a word.
   assign unused_addr_bits = ^{gen_addr[0][15:AW], gen_addr[1][15:AW]};

   always_ff @(posedge clk) begin
      if (fire[0]) mem[waddr] <= port_0;
   end

`ifdef LAKE_SPEC_RAW_BYPASS_EN
   assign rdata = (fire[0] && (waddr == raddr)) ? port_0 : mem[raddr];
`else
   assign rdata = mem[raddr];
`endif

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         port_1 <= '0;
      end else if (flush) begin
         port_1 <= '0;
      end else if (fire[1]) begin
         port_1 <= rdata;
      end
   end

endmodule

// File: tb/tb_lake_spec_mem.sv
// Scoreboard bench for lake_spec_mem: driver queues the expected port_1 for each cycle,
// a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_lake_spec_mem;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         flush = 1'b0;
   logic [549:0] cfg = '0;
   logic [15:0]  port_0 = '0;
   logic [15:0]  port_1;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];
   int          id_q[$];
   int          cyc_q[$];

`ifdef LAKE_SPEC_RAW_BYPASS_EN
   localparam logic [15:0] COLL_EXP = 16'd42;
`else
   localparam logic [15:0] COLL_EXP = 16'd7;
`endif

   always #5 clk = ~clk;

   lake_spec_mem dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .flush                  (flush),
      .config_memory_size_550 (cfg),
      .port_0                 (port_0),
      .port_1                 (port_1)
   );

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached with %0d entries pending", exp_q.size());
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [15:0] e;
         int id, t;
         e  = exp_q.pop_front();
         id = id_q.pop_front();
         t  = cyc_q.pop_front();
         checks++;
         if (port_1 !== e) begin
            errors++;
            $display("FAIL test%0d cyc%0d port_1: got %h, expected %h", id, t, port_1, e);
         end
      end
   end

   function automatic logic [274:0] rec(input logic [2:0] dim, input logic [63:0] ext,
                                        input logic [63:0] astr, input logic [15:0] aoff,
                                        input logic [63:0] sstr, input logic [63:0] soff);
      return {soff, sstr, aoff, astr, ext, dim};
   endfunction

   function automatic logic [15:0] exp_copy(input int t);
      if (t < 5) return 16'd0;
      if (t <= 68) return 16'(2 * (t - 5));
      return 16'd126;
   endfunction

   function automatic logic [15:0] exp_tr(input int t);
      int n, a;
      if (t <= 64) return 16'd0;
      if (t > 128) return 16'd190;
      n = t - 65;
      a = 8 * (n % 8) + n / 8;
      return 16'(3 * a + 1);
   endfunction

   task automatic drive(input logic [15:0] p0, input logic [15:0] e, input int id, input int t);
      port_0 = p0;
      exp_q.push_back(e);
      id_q.push_back(id);
      cyc_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int id);
      rst_n = 1'b1;
      flush = 1'b0;
      drive(16'd0, 16'd0, id, -2);
      drive(16'd0, 16'd0, id, -1);
      rst_n = 1'b0;
   endtask

   logic [274:0] copy_p0, copy_p1;

   initial begin
      copy_p0 = rec(3'd1, 64'd64, 64'd1, 16'd0, 64'd1, 64'd0);
      copy_p1 = rec(3'd1, 64'd64, 64'd1, 16'd0, 64'd1, 64'd4);
      @(posedge clk);
      #1;

      // 1: straight copy, 4-cycle schedule offset
      cfg = {copy_p1, copy_p0};
      do_reset(1);
      for (int t = 0; t < 80; t++) drive(16'(2 * t), exp_copy(t), 1, t);

      // 2: 8x8 transpose
      cfg = {rec(3'd2, {16'd0, 16'd0, 16'd8, 16'd8}, {16'd0, 16'd0, 16'd1, 16'd8}, 16'd0,
                 {16'd0, 16'd0, 16'd8, 16'd1}, 64'd64),
             rec(3'd2, {16'd0, 16'd0, 16'd8, 16'd8}, {16'd0, 16'd0, 16'd8, 16'd1}, 16'd0,
                 {16'd0, 16'd0, 16'd8, 16'd1}, 64'd0)};
      do_reset(2);
      for (int t = 0; t < 140; t++)
         drive((t < 64) ? 16'(3 * t + 1) : 16'hFFFF, exp_tr(t), 2, t);

      // 3: write 7 to addr 5 at cyc 5, then write 42 and read addr 5 both at cyc 10
      cfg = {rec(3'd1, 64'd1, 64'd0, 16'd5, 64'd0, 64'd10),
             rec(3'd1, 64'd2, 64'd0, 16'd5, 64'd5, 64'd5)};
      do_reset(3);
      for (int t = 0; t < 16; t++)
         drive((t == 5) ? 16'd7 : (t == 10) ? 16'd42 : 16'hBEEF,
               (t <= 10) ? 16'd0 : COLL_EXP, 3, t);

      // 4: reset during the copy at cyc 20, then the full schedule again from cyc 0
      cfg = {copy_p1, copy_p0};
      do_reset(4);
      for (int t = 0; t < 20; t++) drive(16'(2 * t), exp_copy(t), 4, t);
      rst_n = 1'b1;
      drive(16'd0, 16'd0, 4, 20);
      rst_n = 1'b0;
      for (int t = 0; t < 80; t++) drive(16'(2 * t), exp_copy(t), 4, t);

      // 5: flush at cyc 30, then read old contents ahead of new writes
      do_reset(5);
      for (int t = 0; t < 30; t++)
         drive(16'h500 + 16'(t), (t < 5) ? 16'd0 : 16'h500 + 16'(t - 5), 5, t);
      flush = 1'b1;
      drive(16'd0, 16'h519, 5, 30);
      flush = 1'b0;
      cfg = {rec(3'd1, 64'd30, 64'd1, 16'd0, 64'd1, 64'd0),
             rec(3'd1, 64'd30, 64'd1, 16'd0, 64'd1, 64'd2)};
      for (int t = 0; t < 40; t++)
         drive(16'h700 + 16'(t),
               (t == 0) ? 16'd0 : (t <= 30) ? 16'h500 + 16'(t - 1) : 16'h51D, 5, 100 + t);

      // 6: read port disabled by dim=0
      cfg = {rec(3'd0, 64'd64, 64'd1, 16'd0, 64'd1, 64'd4), copy_p0};
      do_reset(6);
      for (int t = 0; t < 1000; t++) drive(16'(5 * t + 3), 16'd0, 6, t);

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
